// File: rtl/sd_frame_sequencer.sv
// sd_frame_sequencer: streams channel and data words from a stimulus ROM
// into the sphere decoder and queues decoded vectors in an output FIFO.
module sd_frame_sequencer #(
  parameter int WIDTH     = 20,
  parameter int NANT      = 4,
  parameter int BPS       = 3,
  parameter int NCH_WORDS = 3,
  parameter int NDATA     = 11,
  parameter int NFRAMES   = 2000,
  parameter int DEPTH     = 4,
  parameter int HOLDOFF   = 1,
  parameter int TIMEOUT   = 4096,
  parameter int ADDR_W    = 15
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  output logic [ADDR_W-1:0]             MemAddr,
  input  logic [WIDTH*NANT*2-1:0]       MemData,
  output logic                          DecReset,
  output logic                          DecFlag,
  output logic [WIDTH*NANT*2-1:0]       DecInData,
  input  logic [BPS*NANT-1:0]           DecOutData,
  input  logic                          DecOutputReady,
  output logic                          OutValid,
  output logic [BPS*NANT-1:0]           OutData,
  input  logic                          OutReady,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Err,
  output logic [$clog2(NFRAMES+1)-1:0]  FrameCnt
);

  localparam int OW = BPS*NANT;
  localparam int FW = $clog2(NFRAMES+1);
  localparam int CW = $clog2(NCH_WORDS+1);
  localparam int DW = $clog2(NDATA+1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF+1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_CH, S_D0, S_WAIT, S_DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cc;
  logic [DW-1:0] di;
  logic [HW-1:0] hold;
  logic [TW-1:0] wcnt;
  logic [OW-1:0] mem [DEPTH];
  logic [PW:0]   wptr, rptr;

  logic full, pop, push, issue, ld_word, reload;
  logic start_run, frame_inc;
  logic wdt_inc, wdt_fire, hold_dec;

  assign full = (wptr[PW] != rptr[PW]) &&
                (wptr[PW-1:0] == rptr[PW-1:0]);
  assign OutValid = (wptr != rptr);
  assign OutData  = mem[rptr[PW-1:0]];
  assign pop      = OutValid && OutReady;
  assign reload   = (state == S_D0) || issue;

  always_comb begin
    state_n   = state;
    start_run = 1'b0;
    ld_word   = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    frame_inc = 1'b0;
    wdt_inc   = 1'b0;
    wdt_fire  = 1'b0;
    hold_dec  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          start_run = 1'b1;
          state_n   = S_CLR;
        end
      end
      S_CLR: state_n = S_CH;
      S_CH: begin
        ld_word = 1'b1;
        if (cc == CW'(NCH_WORDS-1)) state_n = S_D0;
      end
      S_D0: begin
        ld_word = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (hold != '0) begin
          hold_dec = 1'b1;
        end else if (DecOutputReady) begin
          // a full FIFO stalls the decoder handshake entirely
          if (!full) begin
            push = 1'b1;
            if (di < DW'(NDATA)) begin
              issue   = 1'b1;
              ld_word = 1'b1;
            end else begin
              frame_inc = 1'b1;
              state_n = (FrameCnt == FW'(NFRAMES-1)) ?
                        S_DONE : S_CLR;
            end
          end
        end else if (TIMEOUT != 0) begin
          if (wcnt == TW'(TIMEOUT-1)) begin
            wdt_fire = 1'b1;
            state_n  = S_DONE;
          end else begin
            wdt_inc = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      MemAddr   <= '0;
      DecReset  <= 1'b0;
      DecFlag   <= 1'b1;
      DecInData <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      FrameCnt  <= '0;
      cc        <= '0;
      di        <= '0;
      hold      <= '0;
      wcnt      <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      state    <= state_n;
      DecReset <= (state_n == S_CH) || (state_n == S_D0) ||
                  (state_n == S_WAIT);
      Busy     <= (state_n != S_IDLE) && (state_n != S_DONE);
      Done     <= (state_n == S_DONE);
      if (start_run) begin
        MemAddr  <= '0;
        FrameCnt <= '0;
        Err      <= 1'b0;
      end
      if (ld_word) begin
        DecInData <= MemData;
        MemAddr   <= MemAddr + ADDR_W'(1);
        DecFlag   <= (state == S_CH);
      end else if (state_n == S_CLR) begin
        DecFlag <= 1'b1;
      end
      if (frame_inc) FrameCnt <= FrameCnt + FW'(1);
      if (wdt_fire) Err <= 1'b1;
      cc <= (state == S_CH) ? cc + CW'(1) : '0;
      if (reload) begin
        hold <= HW'(HOLDOFF);
        wcnt <= '0;
      end else begin
        if (hold_dec) hold <= hold - HW'(1);
        if (wdt_inc) wcnt <= wcnt + TW'(1);
      end
      if (state == S_D0) di <= DW'(1);
      else if (issue) di <= di + DW'(1);
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop) rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wptr[PW-1:0]] <= DecOutData;
  end

endmodule
